// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store unit for the 5-stage RV32I pipeline. It turns an
//   M-stage load or store into one transfer on a variable-latency req/ack data
//   bus. It holds the pipeline until that transfer completes, formats store
//   lanes and byte enables, and sign/zero-extends load data. Misaligned
//   accesses, illegal funct3 values and bus timeouts are flagged here. Trap
//   handling is done elsewhere.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   M_MemRead, M_MemWrite    access request from M stage (write wins if both)
//   M_funct3, M_Addr         access size/sign and effective byte address
//   M_WriteData              store data, value in low bits
//   M_ReadData               formatted load result, registered, held
//   lsu_stall                hold F/D/E/M, bubble into W
//   lsu_fault                1-cycle pulse: misaligned or illegal funct3
//   lsu_timeout              1-cycle pulse: bus gave no ack within TIMEOUT
//   bus_req/we/addr/wdata/be request channel, stable while bus_req is high
//   bus_ack, bus_rdata       completion strobe and read data
//
// FSM states
//   state  | meaning
//   S_IDLE | no access in flight; accept a legal access and stall at once
//   S_REQ  | bus_req asserted, waiting for bus_ack or timeout
//   S_DONE | access finished, stall released so the pipeline advances

module load_store_unit #(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  M_MemRead,
  input  logic                  M_MemWrite,
  input  logic [2:0]            M_funct3,
  input  logic [WIDTH_ADDR-1:0] M_Addr,
  input  logic [WIDTH_DATA-1:0] M_WriteData,
  output logic [WIDTH_DATA-1:0] M_ReadData,
  output logic                  lsu_stall,
  output logic                  lsu_fault,
  output logic                  lsu_timeout,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [WIDTH_ADDR-1:0] bus_addr,
  output logic [WIDTH_DATA-1:0] bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_ack,
  input  logic [WIDTH_DATA-1:0] bus_rdata
);

  // The counter counts REQ cycles from 0. It needs to reach TIMEOUT-1, so it
  // needs enough bits for that value. With TIMEOUT=0 it only wraps, and that
  // does no harm.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic             access, illegal, misalign, fault, start;
  logic             ack_hit, tmo_hit;
  logic [31:0]      st_wdata, ld_lane, ld_fmt;
  logic [3:0]       st_be;

  assign access = M_MemRead | M_MemWrite;

  always_comb begin
    illegal  = 1'b0;
    misalign = 1'b0;
    if (M_MemWrite)
      illegal = !(M_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      illegal = !(M_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    if (M_funct3[1:0] == 2'b01)
      misalign = M_Addr[0];
    else if (M_funct3[1:0] == 2'b10)
      misalign = (M_Addr[1:0] != 2'b00);
  end

  assign fault = illegal | misalign;
  assign start = (state == S_IDLE) && access && !fault;

  // Store data goes on every lane it could land in. The slave picks the live
  // bytes using the byte enables.
  always_comb begin
    st_wdata = M_WriteData;
    st_be    = 4'b1111;
    case (M_funct3[1:0])
      2'b00: begin
        st_wdata = {4{M_WriteData[7:0]}};
        st_be    = 4'b0001 << M_Addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{M_WriteData[15:0]}};
        st_be    = 4'b0011 << M_Addr[1:0];
      end
      default: ;
    endcase
  end

  assign ld_lane = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_fmt = ld_lane;
    case (f3_q)
      3'b000:  ld_fmt = {{24{ld_lane[7]}}, ld_lane[7:0]};
      3'b100:  ld_fmt = {24'h0, ld_lane[7:0]};
      3'b001:  ld_fmt = {{16{ld_lane[15]}}, ld_lane[15:0]};
      3'b101:  ld_fmt = {16'h0, ld_lane[15:0]};
      default: ld_fmt = ld_lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: if (start) state_nxt = S_REQ;
      S_REQ: begin
        if (bus_ack) begin
          ack_hit   = 1'b1;
          state_nxt = S_DONE;
        end else if (TIMEOUT != 0 && cnt == CNT_TC) begin
          tmo_hit   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // bus_req comes from the state, so an async reset drops it immediately.
  // The stall is gated by rst because the M-stage inputs may still show an
  // access while reset is held.
  assign bus_req   = (state == S_REQ);
  assign lsu_stall = !rst && (start || state == S_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      M_ReadData  <= '0;
      lsu_fault   <= 1'b0;
      lsu_timeout <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      bus_be      <= 4'b0000;
      cnt         <= '0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
    end else begin
      lsu_fault   <= (state == S_IDLE) && access && fault;
      lsu_timeout <= tmo_hit;
      if (state == S_REQ) cnt <= cnt + CNT_W'(1);
      else                cnt <= '0;
      if (start) begin
        bus_we    <= M_MemWrite;
        bus_addr  <= {M_Addr[WIDTH_ADDR-1:2], 2'b00};
        bus_be    <= M_MemWrite ? st_be : 4'b1111;
        bus_wdata <= M_MemWrite ? st_wdata : '0;
        f3_q      <= M_funct3;
        off_q     <= M_Addr[1:0];
      end
      if (ack_hit && !bus_we)      M_ReadData <= ld_fmt;
      else if (tmo_hit && !bus_we) M_ReadData <= '0;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. The reference model computes the expected
// bus request, byte enables, lane data, stall length and load result for each
// access, using byte arithmetic and the documented latency. One compare
// process checks the DUT against that model on every clock cycle. Directed
// accesses pin the model with literal values, and randomized accesses follow.

module tb_load_store_unit;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        M_MemRead = 1'b0, M_MemWrite = 1'b0;
  logic [2:0]  M_funct3 = 3'b000;
  logic [31:0] M_Addr = '0, M_WriteData = '0, M_ReadData;
  logic        lsu_stall, lsu_fault, lsu_timeout;
  logic        bus_req, bus_we, bus_ack = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
  logic [3:0]  bus_be;

  load_store_unit #(.WIDTH_DATA(32), .WIDTH_ADDR(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .M_MemRead(M_MemRead), .M_MemWrite(M_MemWrite), .M_funct3(M_funct3),
    .M_Addr(M_Addr), .M_WriteData(M_WriteData), .M_ReadData(M_ReadData),
    .lsu_stall(lsu_stall), .lsu_fault(lsu_fault), .lsu_timeout(lsu_timeout),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h expected=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle behaviour, set by the driver together with the stimulus.
  bit          cmp_en = 1'b0;
  logic        exp_stall = 0, exp_req = 0, exp_fault = 0, exp_tmo = 0, exp_we = 0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rdata = '0;
  logic [3:0]  exp_be = '0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", {31'b0, lsu_stall}, {31'b0, exp_stall});
      chk("bus_req", {31'b0, bus_req}, {31'b0, exp_req});
      chk("fault", {31'b0, lsu_fault}, {31'b0, exp_fault});
      chk("timeout", {31'b0, lsu_timeout}, {31'b0, exp_tmo});
      chk("read_data", M_ReadData, exp_rdata);
      if (exp_req) begin
        chk("bus_addr", bus_addr, exp_addr);
        chk("bus_we", {31'b0, bus_we}, {31'b0, exp_we});
        chk("bus_be", {28'b0, bus_be}, {28'b0, exp_be});
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wdata);
      end
    end
  end

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    int          nbytes;
    logic [31:0] mask, v;
    nbytes = 1 << f3[1:0];
    mask   = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    v      = (rdata >> (8 * off)) & mask;
    if (!f3[2] && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
    return v;
  endfunction

  int          obs_stall, obs_reqcnt;
  bit          obs_fault, obs_tmo;
  logic [31:0] obs_addr, obs_wdata, obs_rd;
  logic [3:0]  obs_be;

  task automatic observe();
    @(negedge clk);
    if (lsu_stall) obs_stall++;
    if (bus_req) begin
      obs_reqcnt++;
      obs_addr  = bus_addr;
      obs_wdata = bus_wdata;
      obs_be    = bus_be;
    end
    if (lsu_fault) obs_fault = 1'b1;
    if (lsu_timeout) obs_tmo = 1'b1;
    obs_rd = M_ReadData;
  endtask

  task automatic idle_inputs();
    M_MemRead  = 1'b0;
    M_MemWrite = 1'b0;
    // Acks outside REQ must be ignored.
    bus_ack    = 1'($urandom_range(0, 1));
    bus_rdata  = $urandom;
  endtask

  // One access: the presenting cycle, then REQ cycles, DONE, and one idle cycle.
  task automatic do_access(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int delay, input bit noack);
    bit         legal, bad;
    int         nbytes, nreq;
    logic [1:0] off;
    obs_stall = 0; obs_reqcnt = 0; obs_fault = 0; obs_tmo = 0;
    nbytes = 1 << f3[1:0];
    off    = addr[1:0];
    legal  = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    bad    = !legal || ((addr % nbytes) != 0);

    @(posedge clk); #1;
    M_MemRead = rd; M_MemWrite = wr; M_funct3 = f3; M_Addr = addr; M_WriteData = wd;
    bus_ack = 1'b0;
    exp_req = 0; exp_fault = 0; exp_tmo = 0; exp_stall = !bad;
    observe();

    if (bad) begin
      @(posedge clk); #1;
      idle_inputs();
      exp_stall = 0; exp_fault = 1;
      observe();
      return;
    end

    exp_we   = wr;
    exp_addr = {addr[31:2], 2'b00};
    if (wr) begin
      exp_be = '0;
      for (int i = 0; i < nbytes; i++) exp_be[off + i] = 1'b1;
      for (int i = 0; i < 4; i++) exp_wdata[8 * i +: 8] = wd[8 * (i % nbytes) +: 8];
    end else begin
      exp_be = 4'b1111;
    end

    nreq = noack ? TMO : delay + 1;
    for (int c = 1; c <= nreq; c++) begin
      @(posedge clk); #1;
      exp_req = 1; exp_stall = 1;
      bus_ack   = (!noack && c == nreq);
      bus_rdata = bus_ack ? rdata : $urandom;
      observe();
    end

    @(posedge clk); #1;
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    exp_req = 0; exp_stall = 0; exp_tmo = noack;
    if (!wr) exp_rdata = noack ? 32'h0 : load_model(f3, off, rdata);
    observe();

    @(posedge clk); #1;
    idle_inputs();
    exp_tmo = 0;
    observe();
  endtask

  initial begin
    #200_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state, with an access already presented while rst is high.
    M_MemRead = 1'b1; M_funct3 = 3'b010; M_Addr = 32'h100;
    #12;
    chk("rst_stall", {31'b0, lsu_stall}, 32'h0);
    chk("rst_req", {31'b0, bus_req}, 32'h0);
    chk("rst_read_data", M_ReadData, 32'h0);
    chk("rst_be", {28'b0, bus_be}, 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_fault", {31'b0, lsu_fault}, 32'h0);
    M_MemRead = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    cmp_en = 1'b1;

    do_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0);
    chk("sw_stall_cycles", obs_stall, 2);
    chk("sw_be", {28'b0, obs_be}, 32'hF);
    chk("sw_wdata", obs_wdata, 32'hDEADBEEF);
    chk("sw_addr", obs_addr, 32'h100);

    do_access(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 0);
    chk("sb_be", {28'b0, obs_be}, 32'h8);
    chk("sb_wdata", obs_wdata, 32'hA5A5A5A5);

    do_access(1, 0, 3'b000, 32'h103, 32'h0, 32'hA5000000, 0, 0);
    chk("lb_data", obs_rd, 32'hFFFFFFA5);
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 32'hA5000000, 0, 0);
    chk("lbu_data", obs_rd, 32'h000000A5);

    do_access(1, 0, 3'b001, 32'h102, 32'h0, 32'h80010000, 4, 0);
    chk("lh_stall_cycles", obs_stall, 6);
    chk("lh_data", obs_rd, 32'hFFFF8001);

    do_access(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    chk("lw_mis_fault", {31'b0, obs_fault}, 32'h1);
    chk("lw_mis_req", obs_reqcnt, 0);
    chk("lw_mis_stall", obs_stall, 0);
    chk("lw_mis_keep_data", obs_rd, 32'hFFFF8001);
    do_access(0, 1, 3'b011, 32'h100, 32'h1234, 32'h0, 0, 0);
    chk("st011_fault", {31'b0, obs_fault}, 32'h1);
    chk("st011_req", obs_reqcnt, 0);

    do_access(1, 0, 3'b010, 32'h200, 32'h0, 32'h0, 0, 1);
    chk("tmo_pulse", {31'b0, obs_tmo}, 32'h1);
    chk("tmo_req_cycles", obs_reqcnt, 16);
    chk("tmo_stall_cycles", obs_stall, 17);
    chk("tmo_data", obs_rd, 32'h0);

    for (int n = 0; n < 300; n++) begin
      bit         rd, wr, noack;
      logic [2:0] f3;
      logic [31:0] addr;
      int         kind;
      kind  = $urandom_range(0, 9);
      wr    = (kind < 4);
      rd    = !wr || (kind == 0);
      f3    = 3'($urandom_range(0, 7));
      addr  = {$urandom_range(0, 32'hFFFF), 2'b00} | 32'($urandom_range(0, 3));
      // Bias toward legal, aligned accesses so most take the bus path.
      if ($urandom_range(0, 3) != 0) begin
        f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
        if (!wr && f3 == 3'd3) f3 = 3'd4;
        if (f3[1:0] == 2'b01) addr[0] = 1'b0;
        if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
      end
      noack = ($urandom_range(0, 19) == 0);
      do_access(rd, wr, f3, addr, $urandom, $urandom, $urandom_range(0, 5), noack);
    end

    // Async reset while a request is outstanding.
    cmp_en = 1'b0;
    @(posedge clk); #1;
    M_MemRead = 1'b1; M_MemWrite = 1'b0; M_funct3 = 3'b010; M_Addr = 32'h300;
    bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_rst_req", {31'b0, bus_req}, 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'b0, bus_req}, 32'h0);
    chk("mid_rst_stall", {31'b0, lsu_stall}, 32'h0);
    chk("mid_rst_data", M_ReadData, 32'h0);
    M_MemRead = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    exp_rdata = 32'h0; exp_stall = 0; exp_req = 0; exp_fault = 0; exp_tmo = 0;
    cmp_en = 1'b1;
    do_access(0, 1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 2, 0);
    chk("post_rst_stall", obs_stall, 4);
    chk("post_rst_wdata", obs_wdata, 32'hCAFEF00D);
    chk("post_rst_addr", obs_addr, 32'h104);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
